// File: rtl/noc_multi_stream_controller.sv
// Multi-channel GLB->GIN NoC controller. NUM_CH channels share one GLB read port
// through a round-robin arbiter; each granted channel bursts pack_n GLB words, packs
// them LSB-first into one GIN word and writes it together with its (row,col) tag.
module noc_multi_stream_controller #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned ADDR_WIDTH = 20,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned PACK       = 4,
   parameter int unsigned ROW_TAG_W  = 4,
   parameter int unsigned COL_TAG_W  = 5,
   parameter int unsigned ROW_MAJOR  = 1,
   localparam int unsigned PN_W      = $clog2(PACK + 1),
   localparam int unsigned OUT_WIDTH = DATA_WIDTH * PACK
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   output logic                          done,
   input  logic [NUM_CH-1:0]             ch_en,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]  base_addr,
   input  logic [NUM_CH*ROW_TAG_W-1:0]   num_rows,
   input  logic [NUM_CH*COL_TAG_W-1:0]   num_cols,
   input  logic [NUM_CH*PN_W-1:0]        pack_n,
   output logic [NUM_CH-1:0]             ch_done,
   output logic                          glb_re,
   output logic [ADDR_WIDTH-1:0]         glb_addr,
   input  logic [DATA_WIDTH-1:0]         glb_din,
   input  logic [NUM_CH-1:0]             gin_full,
   input  logic [NUM_CH-1:0]             tags_full,
   output logic [NUM_CH-1:0]             gin_we,
   output logic [OUT_WIDTH-1:0]          gin_dout,
   output logic [NUM_CH-1:0]             tags_we,
   output logic [ROW_TAG_W-1:0]          row_tag,
   output logic [COL_TAG_W-1:0]          col_tag
);

   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {StIdle, StArb, StRead, StWrite} state_e;

   state_e                 state_q, state_d;
   logic                   done_q, done_d;
   logic [NUM_CH-1:0]      ch_done_q, ch_done_d;
   logic [NUM_CH-1:0]      en_q, en_d;
   logic [ROW_TAG_W-1:0]   rows_q [NUM_CH];
   logic [ROW_TAG_W-1:0]   rows_d [NUM_CH];
   logic [COL_TAG_W-1:0]   cols_q [NUM_CH];
   logic [COL_TAG_W-1:0]   cols_d [NUM_CH];
   logic [PN_W-1:0]        pn_q   [NUM_CH];
   logic [PN_W-1:0]        pn_d   [NUM_CH];
   logic [ADDR_WIDTH-1:0]  addr_q [NUM_CH];
   logic [ADDR_WIDTH-1:0]  addr_d [NUM_CH];
   logic [ROW_TAG_W-1:0]   row_q  [NUM_CH];
   logic [ROW_TAG_W-1:0]   row_d  [NUM_CH];
   logic [COL_TAG_W-1:0]   col_q  [NUM_CH];
   logic [COL_TAG_W-1:0]   col_d  [NUM_CH];
   // rr_q holds the first index to consider, i.e. one past the last granted channel
   logic [CH_W-1:0]        rr_q, rr_d;
   logic [CH_W-1:0]        gnt_q, gnt_d;
   logic [PN_W-1:0]        k_q, k_d;
   logic [OUT_WIDTH-1:0]   pack_q, pack_d;

   logic [NUM_CH-1:0]      eligible;
   logic                   gnt_found;
   logic [CH_W-1:0]        gnt_idx;

   // Round-robin search starting at rr_q; full flags only matter at grant time
   always_comb begin
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      eligible  = en_q & ~ch_done_q & ~gin_full & ~tags_full;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         idx = int'(rr_q) + i;
         if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
         if (!gnt_found && eligible[idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(idx);
         end
      end
   end

   // Next-state logic: config latch, arbitration, burst read and tag counter advance
   always_comb begin
      logic [PN_W-1:0]      pn_raw;
      logic                 act;
      logic                 any_act;
      logic                 last_row;
      logic                 last_col;
      int                   slot;
      pn_raw    = '0;
      act       = 1'b0;
      any_act   = 1'b0;
      last_row  = 1'b0;
      last_col  = 1'b0;
      slot      = 0;
      state_d   = state_q;
      done_d    = done_q;
      ch_done_d = ch_done_q;
      en_d      = en_q;
      rows_d    = rows_q;
      cols_d    = cols_q;
      pn_d      = pn_q;
      addr_d    = addr_q;
      row_d     = row_q;
      col_d     = col_q;
      rr_d      = rr_q;
      gnt_d     = gnt_q;
      k_d       = k_q;
      pack_d    = pack_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               done_d = 1'b0;
               en_d   = ch_en;
               for (int c = 0; c < int'(NUM_CH); c++) begin
                  rows_d[c] = num_rows[c*ROW_TAG_W +: ROW_TAG_W];
                  cols_d[c] = num_cols[c*COL_TAG_W +: COL_TAG_W];
                  addr_d[c] = base_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                  row_d[c]  = '0;
                  col_d[c]  = '0;
                  // Clamp transfer length into 1..PACK
                  pn_raw = pack_n[c*PN_W +: PN_W];
                  if (pn_raw == '0) pn_d[c] = PN_W'(1);
                  else if (pn_raw > PN_W'(PACK)) pn_d[c] = PN_W'(PACK);
                  else pn_d[c] = pn_raw;
                  act = ch_en[c] && (rows_d[c] != '0) && (cols_d[c] != '0);
                  ch_done_d[c] = !act;
                  any_act = any_act | act;
               end
               // Nothing to move: report completion right away
               if (any_act) state_d = StArb;
               else done_d = 1'b1;
            end
         end
         StArb: begin
            if (&ch_done_q) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else if (gnt_found) begin
               gnt_d   = gnt_idx;
               rr_d    = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
               k_d     = '0;
               pack_d  = '0;
               state_d = StRead;
            end
         end
         StRead: begin
            addr_d[gnt_q] = addr_q[gnt_q] + ADDR_WIDTH'(1);
            // glb_din carries the word requested one cycle earlier
            if (k_q != '0) begin
               slot = int'(k_q) - 1;
               pack_d[slot*DATA_WIDTH +: DATA_WIDTH] = glb_din;
            end
            k_d = k_q + PN_W'(1);
            if (k_q == pn_q[gnt_q] - PN_W'(1)) state_d = StWrite;
         end
         StWrite: begin
            last_row = (row_q[gnt_q] == rows_q[gnt_q] - ROW_TAG_W'(1));
            last_col = (col_q[gnt_q] == cols_q[gnt_q] - COL_TAG_W'(1));
            if (ROW_MAJOR != 0) begin
               if (last_col) begin
                  col_d[gnt_q] = '0;
                  if (last_row) begin
                     row_d[gnt_q]     = '0;
                     ch_done_d[gnt_q] = 1'b1;
                  end else begin
                     row_d[gnt_q] = row_q[gnt_q] + ROW_TAG_W'(1);
                  end
               end else begin
                  col_d[gnt_q] = col_q[gnt_q] + COL_TAG_W'(1);
               end
            end else begin
               if (last_row) begin
                  row_d[gnt_q] = '0;
                  if (last_col) begin
                     col_d[gnt_q]     = '0;
                     ch_done_d[gnt_q] = 1'b1;
                  end else begin
                     col_d[gnt_q] = col_q[gnt_q] + COL_TAG_W'(1);
                  end
               end else begin
                  row_d[gnt_q] = row_q[gnt_q] + ROW_TAG_W'(1);
               end
            end
            state_d = StArb;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from registered state; the last packed word bypasses pack_q
   always_comb begin
      int last;
      last     = 0;
      glb_re   = 1'b0;
      glb_addr = '0;
      gin_we   = '0;
      tags_we  = '0;
      gin_dout = '0;
      row_tag  = '0;
      col_tag  = '0;
      if (state_q == StRead) begin
         glb_re   = 1'b1;
         glb_addr = addr_q[gnt_q];
      end
      if (state_q == StWrite) begin
         last           = int'(pn_q[gnt_q]) - 1;
         gin_we[gnt_q]  = 1'b1;
         tags_we[gnt_q] = 1'b1;
         gin_dout       = pack_q;
         gin_dout[last*DATA_WIDTH +: DATA_WIDTH] = glb_din;
         row_tag        = row_q[gnt_q];
         col_tag        = col_q[gnt_q];
      end
   end

   assign done    = done_q;
   assign ch_done = ch_done_q;

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         done_q    <= 1'b0;
         ch_done_q <= '0;
         en_q      <= '0;
         rr_q      <= '0;
         gnt_q     <= '0;
         k_q       <= '0;
         pack_q    <= '0;
         for (int c = 0; c < int'(NUM_CH); c++) begin
            rows_q[c] <= '0;
            cols_q[c] <= '0;
            pn_q[c]   <= '0;
            addr_q[c] <= '0;
            row_q[c]  <= '0;
            col_q[c]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         done_q    <= done_d;
         ch_done_q <= ch_done_d;
         en_q      <= en_d;
         rr_q      <= rr_d;
         gnt_q     <= gnt_d;
         k_q       <= k_d;
         pack_q    <= pack_d;
         rows_q    <= rows_d;
         cols_q    <= cols_d;
         pn_q      <= pn_d;
         addr_q    <= addr_d;
         row_q     <= row_d;
         col_q     <= col_d;
      end
   end

endmodule
